// File: rtl/blockram_access_arbiter_pkg.sv
// blockram_access_arbiter shared constants and types.
// Imported by the arbiter, its interface and the response FIFO.
package blockram_access_arbiter_pkg;
  localparam int ENTRY_W = 64;
  localparam int NUM_SET = 64;
  localparam int SET_W = 6;
  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;
  localparam int RESP_FIFO_DEPTH = 2;

  typedef struct packed {
    logic id;
    logic is_write;
  } resp_tag_t;
endpackage

// File: rtl/blockram_access_arbiter_if.sv
// Request and response channels of the blockram arbiter.
// slave = arbiter side, master = requesters plus response consumer.
interface blockram_access_arbiter_if
  import blockram_access_arbiter_pkg::*;
#(
  parameter int W = ENTRY_W,
  parameter int A = SET_W
);
  logic         req0_valid_in;
  logic         req0_ready_out;
  logic         req0_is_write_in;
  logic [A-1:0] req0_addr_in;
  logic [W-1:0] req0_data_in;
  logic         req1_valid_in;
  logic         req1_ready_out;
  logic         req1_is_write_in;
  logic [A-1:0] req1_addr_in;
  logic [W-1:0] req1_data_in;
  logic         resp_valid_out;
  logic         resp_ready_in;
  logic         resp_id_out;
  logic         resp_is_write_out;
  logic [W-1:0] resp_data_out;

  modport slave (
    input  req0_valid_in, req0_is_write_in,
    input  req0_addr_in, req0_data_in,
    output req0_ready_out,
    input  req1_valid_in, req1_is_write_in,
    input  req1_addr_in, req1_data_in,
    output req1_ready_out,
    output resp_valid_out, resp_id_out,
    output resp_is_write_out, resp_data_out,
    input  resp_ready_in
  );

  modport master (
    output req0_valid_in, req0_is_write_in,
    output req0_addr_in, req0_data_in,
    input  req0_ready_out,
    output req1_valid_in, req1_is_write_in,
    output req1_addr_in, req1_data_in,
    input  req1_ready_out,
    input  resp_valid_out, resp_id_out,
    input  resp_is_write_out, resp_data_out,
    output resp_ready_in
  );
endinterface

// File: rtl/blockram_access_arbiter_resp.sv
// blockram_resp_fifo: 2-entry response queue.
// Overflow is prevented upstream by the arbiter's credit check.
module blockram_resp_fifo
  import blockram_access_arbiter_pkg::*;
#(
  parameter int W = 2 + ENTRY_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;

  assign do_pop = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q ^ push_i;
    rd_d  = rd_q ^ do_pop;
    cnt_d = cnt_q + {1'b0, push_i}
                  - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) mem_q[wr_q] <= push_data_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == 2'(RESP_FIFO_DEPTH));
  assign empty_o = (cnt_q == 2'd0);
endmodule

// File: rtl/blockram_access_arbiter.sv
// Round-robin arbiter sharing one dual-port blockram between two
// requesters, with a credit-checked 2-entry response queue.
module blockram_access_arbiter
  import blockram_access_arbiter_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = ENTRY_W,
  parameter int NUM_SET = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = SET_W
) (
  input  logic clk_in,
  input  logic reset_in,
  blockram_access_arbiter_if.slave bus,
  output logic ram_read_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]
               ram_read_set_addr_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]
               ram_read_entry_in,
  output logic ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]
               ram_write_set_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]
               ram_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]
               ram_evict_entry_in
);
  localparam int W  = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int A  = SET_PTR_WIDTH_IN_BITS;
  localparam int FW = 2 + W;

  logic      rr_q, rr_d;
  logic      infl_q, infl_d;
  resp_tag_t tag_q, tag_d;

  logic          v0, v1;
  logic          gnt0, gnt1, gnt;
  logic          sel_wr;
  logic [A-1:0]  sel_addr;
  logic [W-1:0]  sel_data;
  logic          pop, credit_ok;
  logic [2:0]    occ;
  logic [FW-1:0] push_data, head;
  logic [1:0]    f_count;
  logic          f_full, f_empty;

  assign v0 = bus.req0_valid_in;
  assign v1 = bus.req1_valid_in;

  assign pop = !f_empty && bus.resp_ready_in;
  // Responses granted but not yet consumed, after this cycle's pop.
  assign occ = {1'b0, f_count} + {2'b0, infl_q}
             - {2'b0, pop};
  assign credit_ok = (occ < 3'd2);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (credit_ok && reset_in) begin
      unique case (1'b1)
        (v0 && v1): begin
          gnt0 = (rr_q == REQ_ID_0);
          gnt1 = (rr_q == REQ_ID_1);
        end
        (v0 && !v1): gnt0 = 1'b1;
        (!v0 && v1): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt = gnt0 | gnt1;
  assign bus.req0_ready_out = gnt0;
  assign bus.req1_ready_out = gnt1;

  always_comb begin
    sel_wr   = bus.req0_is_write_in;
    sel_addr = bus.req0_addr_in;
    sel_data = bus.req0_data_in;
    if (gnt1) begin
      sel_wr   = bus.req1_is_write_in;
      sel_addr = bus.req1_addr_in;
      sel_data = bus.req1_data_in;
    end
  end

  always_comb begin
    ram_read_en_out        = gnt && !sel_wr;
    ram_write_en_out       = gnt && sel_wr;
    ram_read_set_addr_out  = '0;
    ram_write_set_addr_out = '0;
    ram_write_entry_out    = '0;
    if (ram_read_en_out)
      ram_read_set_addr_out = sel_addr;
    if (ram_write_en_out) begin
      ram_write_set_addr_out = sel_addr;
      ram_write_entry_out    = sel_data;
    end
  end

  always_comb begin
    rr_d   = rr_q;
    infl_d = gnt;
    tag_d  = tag_q;
    if (gnt0) rr_d = REQ_ID_1;
    if (gnt1) rr_d = REQ_ID_0;
    if (gnt) begin
      tag_d.id       = gnt1 ? REQ_ID_1 : REQ_ID_0;
      tag_d.is_write = sel_wr;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rr_q   <= REQ_ID_0;
      infl_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      infl_q <= infl_d;
      tag_q  <= tag_d;
    end
  end

  assign push_data = {tag_q,
    tag_q.is_write ? ram_evict_entry_in
                   : ram_read_entry_in};

  blockram_resp_fifo #(.W(FW)) u_fifo (
    .clk_i       (clk_in),
    .rst_ni      (reset_in),
    .push_i      (infl_q),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (f_count),
    .full_o      (f_full),
    .empty_o     (f_empty)
  );

  assign bus.resp_valid_out = !f_empty;
  assign bus.resp_id_out =
    !f_empty && head[FW-1];
  assign bus.resp_is_write_out =
    !f_empty && head[FW-2];
  assign bus.resp_data_out =
    f_empty ? '0 : head[W-1:0];
endmodule
